// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
// Provides the mode enum, default prescaler counts and width helpers.
package pwm_pkg;

    typedef enum logic {
        PWM_STD   = 1'b0,
        PWM_SERVO = 1'b1
    } pwm_mode_e;

    localparam int DEF_DIV_STD   = 10416;
    localparam int DEF_DIV_SERVO = 200000;

    // Width at which the servo threshold is evaluated without truncation.
    function automatic int servo_thr_w(input int width, input int span);
        return width + $clog2(span + 1) + 1;
    endfunction

    // Channel index width; one extra code point so out-of-range
    // channels remain expressible and can be flagged.
    function automatic int ch_w(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Duty-write handshake bundle for pwm_multi_ch.
// Ports: valid/ch/duty from master, ready/err back from slave.
interface pwm_multi_ch_if #(
    parameter int CH_W  = 3,
    parameter int WIDTH = 7
);
    logic             valid;
    logic             ready;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] duty;
    logic             err;

    modport master (
        output valid, ch, duty,
        input  ready, err
    );

    modport slave (
        input  valid, ch, duty,
        output ready, err
    );
endinterface

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter for all PWM channels.
// Ports: clk, rst, en, mode_act in; boundary (last tick of period), d out.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int DIV_STD   = DEF_DIV_STD,
    parameter int DIV_SERVO = DEF_DIV_SERVO,
    parameter int Q_W       = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  pwm_mode_e        mode_act,
    output logic             boundary,
    output logic [WIDTH-1:0] d
);

    localparam logic [Q_W-1:0] DIV_S = Q_W'(DIV_STD);
    localparam logic [Q_W-1:0] DIV_V = Q_W'(DIV_SERVO);

    logic [Q_W-1:0] q;
    logic [Q_W-1:0] div;
    logic           tick;

    assign div      = (mode_act == PWM_SERVO) ? DIV_V : DIV_S;
    assign tick     = en & (q == div);
    assign boundary = tick & (&d);

    // Disable holds both counters at zero so a restart begins a
    // fresh period and cannot fire a boundary early.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            q <= '0;
            d <= '0;
        end else if (tick) begin
            q <= '0;
            d <= d + WIDTH'(1);
        end else begin
            q <= q + Q_W'(1);
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with shadowed duty registers and STD/SERVO modes.
// Ports: clk_i, rst_i, en_i, mode_i, wr (write handshake), pwm_o, period_end_o.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 7,
    parameter int DIV_STD    = DEF_DIV_STD,
    parameter int DIV_SERVO  = DEF_DIV_SERVO,
    parameter int SERVO_MIN  = 5,
    parameter int SERVO_SPAN = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            mode_i,
    pwm_multi_ch_if.slave   wr,
    output logic [N_CH-1:0] pwm_o,
    output logic            period_end_o
);

    localparam int CH_W    = ch_w(N_CH);
    localparam int TW      = servo_thr_w(WIDTH, SERVO_SPAN);
    localparam int DIV_MAX = (DIV_STD > DIV_SERVO) ? DIV_STD : DIV_SERVO;
    localparam int Q_RAW   = $clog2(DIV_MAX + 1);
    localparam int Q_W     = (Q_RAW < 1) ? 1 : Q_RAW;

    localparam logic [WIDTH-1:0] FULL = '1;

    pwm_mode_e        mode_act;
    logic             boundary;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] pending [N_CH];
    logic [WIDTH-1:0] active  [N_CH];
    logic             accept;
    logic             ch_ok;
    logic [N_CH-1:0]  hit;

    pwm_timebase #(
        .WIDTH     (WIDTH),
        .DIV_STD   (DIV_STD),
        .DIV_SERVO (DIV_SERVO),
        .Q_W       (Q_W)
    ) u_tb (
        .clk      (clk_i),
        .rst      (rst_i),
        .en       (en_i),
        .mode_act (mode_act),
        .boundary (boundary),
        .d        (d)
    );

    // Writes stall only in the boundary cycle, so the shadow copy
    // into active never races a pending update.
    assign wr.ready = ~boundary;
    assign accept   = wr.valid & wr.ready;
    assign ch_ok    = wr.ch < CH_W'(N_CH);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [TW-1:0] prod;
        logic [TW-1:0] thr;
        logic          std_hit;
        logic          srv_hit;

        assign prod    = TW'(active[g]) * TW'(SERVO_SPAN);
        assign thr     = TW'(SERVO_MIN) + (prod >> WIDTH);
        assign std_hit = (d < active[g]) | (active[g] == FULL);
        assign srv_hit = TW'(d) < thr;
        assign hit[g]  = (mode_act == PWM_SERVO) ? srv_hit : std_hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_act     <= PWM_STD;
            period_end_o <= 1'b0;
            wr.err       <= 1'b0;
            pwm_o        <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            period_end_o <= boundary;
            wr.err       <= accept & ~ch_ok;
            pwm_o        <= en_i ? hit : '0;
            for (int i = 0; i < N_CH; i++) begin
                if (accept && ch_ok && wr.ch == CH_W'(i)) begin
                    pending[i] <= wr.duty;
                end
            end
            if (boundary) begin
                mode_act <= pwm_mode_e'(mode_i);
                for (int i = 0; i < N_CH; i++) begin
                    active[i] <= pending[i];
                end
            end
        end
    end

endmodule
